// File: rtl/frame_grab_pkg.sv
`default_nettype none
// ============================================================================
// Package  : frame_grab_pkg
// Brief    : Shared state encoding, default frame geometry and output-flag
//            decode for the frame grab responder.
// Revision : 1.0 - initial release
// ============================================================================
package frame_grab_pkg;

  // Responder state encoding (3-bit, legacy-compatible constants)
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARM     = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] ERROR   = 3'd4;
  localparam logic [2:0] RELEASE = 3'd5;

  // Default geometry: one 320x240 OV7670 frame, ~1M pixel clocks watchdog
  localparam int unsigned DEF_FRAME_PIXELS   = 76800;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;

  // Handshake / gate flags presented to the outside world
  typedef struct packed {
    logic wen;
    logic started;
    logic done;
    logic error;
  } flags_t;

  // Moore decode: every flag is a pure function of the state register
  function automatic flags_t decode_flags(input logic [2:0] st);
    flags_t f;
    f = '0;
    case (st)
      ARM:     f.started = 1'b1;
      CAPTURE: begin
        f.started = 1'b1;
        f.wen     = 1'b1;
      end
      DONE:    begin
        f.started = 1'b1;
        f.done    = 1'b1;
      end
      ERROR:   begin
        f.started = 1'b1;
        f.done    = 1'b1;
        f.error   = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_grab_responder_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Single-bit two-flop synchronizer with asynchronous active-low
//            reset, for level signals crossing into the pixel clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/frame_grab_responder.sv
`default_nettype none
// ============================================================================
// Module   : frame_grab_responder
// Brief    : Camera-clock responder for the start/started/done/ack photo
//            handshake. Opens the frame-buffer write gate for exactly one
//            complete frame, checks the pixel count and reports done/error.
// Revision : 1.0 - initial release
// ============================================================================
module frame_grab_responder
  import frame_grab_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS   = DEF_FRAME_PIXELS,
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned TO_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  input  logic             vsync,
  input  logic             pix_we_in,
  output logic             wen,
  output logic             started,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [CNT_W-1:0] PIX_MAX    = '1;
  localparam logic [CNT_W-1:0] PIX_TARGET = CNT_W'(FRAME_PIXELS);
  localparam logic [TO_W-1:0]  TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

  logic             start_s;
  logic             ack_s;
  logic             vsync_q;
  logic             vs_rise;
  logic             vs_fall;
  logic             timeout;
  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic [TO_W-1:0]  to_cnt_q,    to_cnt_d;
  flags_t           flags;

  // start and ack arrive from the 25 MHz domain
  sync_2ff u_sync_start (
    .clk   (clk),
    .rst_n (reset),
    .d     (start),
    .q     (start_s)
  );

  sync_2ff u_sync_ack (
    .clk   (clk),
    .rst_n (reset),
    .d     (ack),
    .q     (ack_s)
  );

  // vsync is already pixel-clock synchronous; one register gives edge detect
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;
  // Counter value equal to the limit means the frame took too long
  assign timeout = (to_cnt_q == TO_LIMIT);

  // Next-state, pixel count and watchdog counter
  always_comb begin
    state_d     = state_q;
    pix_count_d = pix_count_q;
    to_cnt_d    = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d     = ARM;
          pix_count_d = '0;
          to_cnt_d    = '0;
        end
      end
      ARM: begin
        if (timeout) begin
          state_d = ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (vs_fall) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // A strobe coinciding with the closing vsync edge still belongs to the frame
        if (pix_we_in && (pix_count_q != PIX_MAX)) begin
          pix_count_d = pix_count_q + 1'b1;
        end
        if (timeout) begin
          state_d = ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (vs_rise) begin
            state_d = (pix_count_d == PIX_TARGET) ? DONE : ERROR;
          end
        end
      end
      DONE, ERROR: begin
        if (ack_s) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Both levels must drop so a held start cannot re-trigger a capture
        if (!ack_s && !start_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pixel count and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pix_count_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pix_count_q <= pix_count_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign flags     = decode_flags(state_q);
  assign wen       = flags.wen;
  assign started   = flags.started;
  assign done      = flags.done;
  assign error     = flags.error;
  assign pix_count = pix_count_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_grab_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_grab_responder
// Brief    : Self-checking bench for frame_grab_responder: directed scenarios
//            with literal expectations plus randomized frames, all compared
//            cycle by cycle against a behavioural handshake model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_grab_responder;

  localparam int FP = 16;
  localparam int CW = 8;
  localparam int TO = 200;
  localparam int TW = 8;
  localparam int PIX_SAT = (1 << CW) - 1;

  localparam int SEL_DONE    = 0;
  localparam int SEL_STARTED = 1;

  // Model phases (bench's own view of the handshake)
  localparam int PH_WAIT_REQ  = 10;
  localparam int PH_WAIT_FALL = 11;
  localparam int PH_IN_FRAME  = 12;
  localparam int PH_REPORT    = 13;
  localparam int PH_HANDBACK  = 14;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic          ack       = 1'b0;
  logic          vsync     = 1'b1;
  logic          pix_we_in = 1'b0;
  logic          wen;
  logic          started;
  logic          done;
  logic          error;
  logic [CW-1:0] pix_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_grab_responder #(
    .FRAME_PIXELS   (FP),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ack       (ack),
    .vsync     (vsync),
    .pix_we_in (pix_we_in),
    .wen       (wen),
    .started   (started),
    .done      (done),
    .error     (error),
    .pix_count (pix_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       m_phase = PH_WAIT_REQ;
  int       m_age   = 0;     // cycles spent armed since the request was taken
  int       m_pix   = 0;
  bit       m_fail  = 1'b0;
  bit [1:0] st_hist = 2'b00; // start as seen 1 and 2 edges ago
  bit [1:0] ak_hist = 2'b00;
  bit       vs_prev = 1'b0;
  int       pix_after;

  always_comb begin
    pix_after = m_pix;
    if (m_phase == PH_IN_FRAME && pix_we_in && m_pix < PIX_SAT) pix_after = m_pix + 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= PH_WAIT_REQ;
      m_age   <= 0;
      m_pix   <= 0;
      m_fail  <= 1'b0;
      st_hist <= 2'b00;
      ak_hist <= 2'b00;
      vs_prev <= 1'b0;
    end else begin
      st_hist <= {st_hist[0], start};
      ak_hist <= {ak_hist[0], ack};
      vs_prev <= vsync;
      if (m_phase == PH_WAIT_REQ) begin
        if (st_hist[1]) begin
          m_phase <= PH_WAIT_FALL;
          m_age   <= 0;
          m_pix   <= 0;
          m_fail  <= 1'b0;
        end
      end else if (m_phase == PH_WAIT_FALL || m_phase == PH_IN_FRAME) begin
        m_pix <= pix_after;
        m_age <= m_age + 1;
        if (m_age == TO) begin
          m_phase <= PH_REPORT;
          m_fail  <= 1'b1;
        end else if (m_phase == PH_WAIT_FALL && !vsync && vs_prev) begin
          m_phase <= PH_IN_FRAME;
        end else if (m_phase == PH_IN_FRAME && vsync && !vs_prev) begin
          m_phase <= PH_REPORT;
          m_fail  <= (pix_after != FP);
        end
      end else if (m_phase == PH_REPORT) begin
        if (ak_hist[1]) m_phase <= PH_HANDBACK;
      end else begin
        if (!ak_hist[1] && !st_hist[1]) m_phase <= PH_WAIT_REQ;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    check("cyc_wen",       32'(wen),       32'(m_phase == PH_IN_FRAME));
    check("cyc_started",   32'(started),   32'(m_phase == PH_WAIT_FALL || m_phase == PH_IN_FRAME || m_phase == PH_REPORT));
    check("cyc_done",      32'(done),      32'(m_phase == PH_REPORT));
    check("cyc_error",     32'(error),     32'(m_phase == PH_REPORT && m_fail));
    check("cyc_pix_count", 32'(pix_count), 32'(m_pix));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int sel);
    return (sel == SEL_DONE) ? done : started;
  endfunction

  task automatic wait_for(input string name, input int sel, input logic val, input int limit, output int waited);
    waited = 0;
    while (sig(sel) !== val && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    check(name, 32'(sig(sel)), 32'(val));
  endtask

  // From ARM with vsync high: open a frame, deliver n counted strobes, close it.
  // A strobe is driven in the opening edge cycle, where it must not count.
  task automatic send_frame(input int n, input bit last_on_rise, input bit dense);
    int cnt;
    int guard;
    cnt   = 0;
    guard = 0;
    @(negedge clk);
    vsync     = 1'b0;
    pix_we_in = 1'b1;
    while (cnt < n - int'(last_on_rise) && guard < 150) begin
      @(negedge clk);
      pix_we_in = dense ? 1'b1 : 1'($urandom_range(0, 1));
      if (pix_we_in) cnt++;
      guard++;
    end
    @(negedge clk);
    vsync     = 1'b1;
    pix_we_in = last_on_rise;
    @(negedge clk);
    pix_we_in = 1'b0;
  endtask

  task automatic handshake(input int ack_delay);
    int w;
    wait_for("hs_done_rise", SEL_DONE, 1'b1, 300, w);
    cyc(ack_delay);
    ack = 1'b1;
    wait_for("hs_done_fall", SEL_DONE, 1'b0, 10, w);
    ack   = 1'b0;
    start = 1'b0;
    cyc(4);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  w;
    bit  wen_seen;
    cyc(3);
    check("reset_wen",       32'(wen),       32'd0);
    check("reset_started",   32'(started),   32'd0);
    check("reset_done",      32'(done),      32'd0);
    check("reset_pix_count", 32'(pix_count), 32'd0);
    reset = 1'b1;
    cyc(3);

    // Nominal frame, start dropped mid-frame without aborting
    start = 1'b1;
    cyc(2);
    check("nom_started_early", 32'(started), 32'd0);
    cyc(1);
    check("nom_started_at_3", 32'(started), 32'd1);
    start = 1'b0;
    send_frame(FP, 1'b0, 1'b0);
    check("nom_done",  32'(done),      32'd1);
    check("nom_error", 32'(error),     32'd0);
    check("nom_pix",   32'(pix_count), 32'd16);
    check("nom_wen",   32'(wen),       32'd0);
    ack = 1'b1;
    cyc(2);
    check("nom_done_held", 32'(done), 32'd1);
    cyc(1);
    check("nom_done_clear", 32'(done), 32'd0);
    ack = 1'b0;
    cyc(4);
    check("nom_pix_kept", 32'(pix_count), 32'd16);

    // Short frame: last strobe lands on the closing edge and counts
    start = 1'b1;
    cyc(3);
    send_frame(FP - 1, 1'b1, 1'b1);
    check("short_done",  32'(done),      32'd1);
    check("short_error", 32'(error),     32'd1);
    check("short_pix",   32'(pix_count), 32'd15);
    handshake(2);

    // Arm while a frame is already in progress: nothing until the next frame
    vsync = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pix_we_in = 1'($urandom_range(0, 1));
    end
    pix_we_in = 1'b1;
    cyc(1);
    check("mid_started", 32'(started),   32'd1);
    check("mid_no_wen",  32'(wen),       32'd0);
    check("mid_pix",     32'(pix_count), 32'd0);
    vsync     = 1'b1;
    cyc(3);
    pix_we_in = 1'b0;
    send_frame(FP, 1'b0, 1'b0);
    check("mid_done",  32'(done),      32'd1);
    check("mid_error", 32'(error),     32'd0);
    check("mid_pix16", 32'(pix_count), 32'd16);
    handshake(1);

    // Timeout: vsync never falls
    start = 1'b1;
    cyc(3);
    wen_seen = 1'b0;
    w = 0;
    while (done !== 1'b1 && w < 260) begin
      @(negedge clk);
      w++;
      if (wen) wen_seen = 1'b1;
    end
    check("to_cycles", 32'(w),        32'(TO + 1));
    check("to_error",  32'(error),    32'd1);
    check("to_done",   32'(done),     32'd1);
    check("to_no_wen", 32'(wen_seen), 32'd0);
    handshake(0);

    // Reset in the middle of a capture
    start = 1'b1;
    cyc(3);
    @(negedge clk);
    vsync = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pix_we_in = 1'b1;
    end
    @(negedge clk);
    pix_we_in = 1'b0;
    check("rst_pre_wen", 32'(wen),       32'd1);
    check("rst_pre_pix", 32'(pix_count), 32'd5);
    reset = 1'b0;
    start = 1'b0;
    vsync = 1'b1;
    #1;
    check("rst_wen",     32'(wen),       32'd0);
    check("rst_started", 32'(started),   32'd0);
    check("rst_pix",     32'(pix_count), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(8);
    check("rst_stays_idle", 32'(started), 32'd0);
    start = 1'b1;
    cyc(3);
    check("rst_fresh_start", 32'(started), 32'd1);
    send_frame(FP, 1'b1, 1'b1);
    check("rst_fresh_done", 32'(error), 32'd0);
    handshake(3);

    // Held start through ack: no re-trigger until start rises again
    start = 1'b1;
    cyc(3);
    send_frame(FP, 1'b0, 1'b1);
    ack = 1'b1;
    wait_for("held_release", SEL_STARTED, 1'b0, 10, w);
    ack = 1'b0;
    cyc(8);
    check("held_no_retrigger", 32'(started), 32'd0);
    start = 1'b0;
    cyc(5);
    check("held_idle", 32'(started), 32'd0);
    start = 1'b1;
    cyc(3);
    check("held_rearm", 32'(started), 32'd1);
    send_frame(FP, 1'b0, 1'b1);
    handshake(0);

    // Randomized frames, checked by the model every cycle
    for (int f = 0; f < 14; f++) begin
      cyc($urandom_range(0, 5));
      start = 1'b1;
      for (int b = 0; b < int'($urandom_range(3, 12)); b++) begin
        @(negedge clk);
        pix_we_in = 1'($urandom_range(0, 1));
      end
      pix_we_in = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        wait_for("rnd_timeout_done", SEL_DONE, 1'b1, 260, w);
      end else begin
        if ($urandom_range(0, 1) == 1) start = 1'b0;
        send_frame(int'($urandom_range(FP - 2, FP + 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      handshake(int'($urandom_range(0, 4)));
    end

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/frame_grab_responder.md
# frame_grab_responder

Camera-side responder for the main FSM's start/started/done/ack photo handshake. Runs on the camera pixel clock, arms on a synchronized start request, and opens the frame-buffer write enable for exactly one complete OV7670 frame. It checks the written pixel count against the expected frame size and reports done or error back to the 25 MHz main FSM. It sits between the main FSM and the capture block's write strobe feeding both frame buffers.

## Interface
Parameters:
- FRAME_PIXELS, 76800: pixel writes expected per frame (320x240).
- CNT_W, 17: width of pixel counter, must hold FRAME_PIXELS.
- TIMEOUT_CYCLES, 1_000_000: max clk cycles from arm to frame end.
- TO_W, 20: timeout counter width, ≥ clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  camera pixel clock (cam_pck); sole clock.
- reset  in  1  asynchronous, active-low (CPU_RESETN_DB).
- start  in  1  level request from main FSM, asynchronous to clk.
- ack  in  1  level acknowledge from main FSM, asynchronous to clk.
- vsync  in  1  camera vsync, clk-synchronous, high = vertical blanking.
- pix_we_in  in  1  raw write strobe from capture block.
- wen  out  1  frame-buffer write gate; AND with pix_we_in externally.
- started  out  1  request accepted.
- done  out  1  frame finished (success or error).
- error  out  1  frame failed (count mismatch or timeout).
- pix_count  out  CNT_W  pixels counted in last/current capture.

## Operation
- start and ack each pass through a 2-flop synchronizer (start_s, ack_s); vsync_q registers vsync. Rise = vsync & ~vsync_q; fall = ~vsync & vsync_q.
- Moore FSM, outputs decoded from state register:
  - IDLE: all outputs 0. start_s=1 → ARM; pix_count and timeout counter cleared.
  - ARM: started=1. vsync fall → CAPTURE. Timeout → ERROR.
  - CAPTURE: started=1, wen=1. Each cycle with pix_we_in=1 increments pix_count, saturating at 2^CNT_W-1. vsync rise → DONE if pix_count==FRAME_PIXELS, else ERROR. Timeout → ERROR.
  - DONE: started=1, done=1. ack_s=1 → RELEASE.
  - ERROR: started=1, done=1, error=1. ack_s=1 → RELEASE.
  - RELEASE: all flags 0, wen=0. ack_s=0 and start_s=0 → IDLE.
- Timeout: counter runs in ARM and CAPTURE. Reaching TIMEOUT_CYCLES is a timeout; takes priority over a same-cycle vsync edge.
- start falling while in ARM/CAPTURE does not abort; the frame completes.
- pix_count holds its value from DONE/ERROR through RELEASE and IDLE until the next IDLE→ARM.
- Illegal state encoding → IDLE.

## Timing
- Reset (async assert, synchronous release): state IDLE; wen, started, done, error = 0; pix_count = 0; synchronizers and vsync_q = 0.
- start edge → started high: 3 clk (2 sync + state register).
- vsync fall seen in cycle N → wen high from N+1. Strobes in cycle N are not counted.
- vsync rise in cycle M → wen low from M+1; done high from M+1. Strobes in cycle M are still counted.
- ack edge → done/started low: 3 clk.
- Reset mid-CAPTURE: wen drops immediately (async). The initiator must restart the handshake.

## Structure
- Shared package frame_grab_pkg: state encoding localparams (IDLE, ARM, CAPTURE, DONE, ERROR, RELEASE, 3-bit) and default FRAME_PIXELS / TIMEOUT_CYCLES constants reused by the top level.
- One sub-module: sync_2ff (1-bit two-flop synchronizer with async active-low reset), instantiated for start and ack.

## Test plan
Bench parameters: FRAME_PIXELS=16, CNT_W=8, TIMEOUT_CYCLES=200, TO_W=8.
- Nominal: raise start; vsync falls; 16 strobes; vsync rises → started at +3 clk, wen over the frame only, done=1, error=0, pix_count=16. Raise then drop ack → flags clear, IDLE.
- Short frame: 15 strobes before vsync rise → done=1, error=1, pix_count=15.
- Mid-frame arm: start raised while vsync low with strobes active → no wen until the next vsync fall; pixels before it are uncounted; full 16-strobe frame → done.
- Timeout: start with vsync held high for 200 cycles → error=1, done=1, wen never asserted.
- Reset mid-CAPTURE after 5 strobes: reset low → wen, started, pix_count = 0 in the same cycle; after release, stays IDLE until a fresh start.
- Held start: keep start=1 through ack → stays in RELEASE until start=0, then no re-trigger until start rises again.
